// File: rtl/shared_intf_arb_pkg.sv
// -----------------------------------------------------------------------------
// shared_intf_arb_pkg
// Shared types and helpers for the shared x/y/z interface arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWN, TURN)
//   rr_pick_t   : result of a round-robin pick (found flag + winner index)
//   rr_pick()   : round-robin search over up to MAX_REQ requesters
// -----------------------------------------------------------------------------
package shared_intf_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request at or above ptr, wrapping modulo n_req. Only the
    // low n_req bits of req are considered; ptr must be below n_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n_req
    );
        rr_pick_t    res;
        int unsigned cand;
        res.found = 1'b0;
        res.idx   = {IDX_W{1'b0}};
        for (int unsigned off = 32'd0; off < MAX_REQ; off++) begin
            // ptr + off stays below 2*n_req, so one subtraction wraps it
            cand = 32'(ptr) + off;
            if (cand >= n_req) begin
                cand = cand - n_req;
            end else begin
                cand = cand;
            end
            if ((off < n_req) && !res.found && req[cand[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[IDX_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shared_intf_arbiter_rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// Combinational round-robin picker.
//   req   : per-requester request vector
//   ptr   : index holding highest priority this round
//   idx   : index of the winning requester (valid when found)
//   found : at least one request is set
// -----------------------------------------------------------------------------
module rr_prio_pick
    import shared_intf_arb_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     found
);

    localparam int OW = $clog2(N_REQ);

    logic [MAX_REQ-1:0] req_ext_s;
    logic [IDX_W-1:0]   ptr_ext_s;
    rr_pick_t           pick_s;

    // Widen to the package helper's fixed width and run the search
    always_comb begin
        req_ext_s = MAX_REQ'(req);
        ptr_ext_s = IDX_W'(ptr);
        pick_s    = rr_pick(req_ext_s, ptr_ext_s, N_REQ);
    end

    assign idx   = OW'(pick_s.idx);
    assign found = pick_s.found;

endmodule

// File: rtl/shared_intf_arbiter.sv
// -----------------------------------------------------------------------------
// shared_intf_arbiter
// Round-robin arbiter sharing one x/y/z interface among N_REQ requesters.
// A grant lasts until the owner drops its request, signals its last beat, or
// has held the interface for MAX_HOLD cycles; TURN_CYC idle cycles follow
// every grant before the next arbitration.
//   i_clk, i_srst          : clock, synchronous active-high reset
//   i_req, i_last          : per-requester request level / end-of-burst
//   i_x, i_y, i_z          : per-requester data, requester k at [k*DATA_W +: DATA_W]
//   o_gnt, o_owner         : registered one-hot grant and owner index
//   o_valid, o_x/o_y/o_z   : shared interface (driven only by a requesting owner)
//   o_timeout              : one-cycle pulse when a grant is cut by MAX_HOLD
// -----------------------------------------------------------------------------
module shared_intf_arbiter
    import shared_intf_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
) (
    input  logic                      i_clk,
    input  logic                      i_srst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_last,
    input  logic [N_REQ*DATA_W-1:0]   i_x,
    input  logic [N_REQ*DATA_W-1:0]   i_y,
    input  logic [N_REQ*DATA_W-1:0]   i_z,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [$clog2(N_REQ)-1:0]  o_owner,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_x,
    output logic [DATA_W-1:0]         o_y,
    output logic [DATA_W-1:0]         o_z,
    output logic                      o_timeout
);

    localparam int OW     = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURN_CYC + 1);

    localparam logic [OW-1:0]     OWNER_MAX = OW'(N_REQ - 1);
    localparam logic [OW-1:0]     OWNER_ONE = OW'(1);
    localparam logic [OW-1:0]     OWNER_ZRO = OW'(0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZRO  = HOLD_W'(0);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [TURN_W-1:0] TURN_ZRO  = TURN_W'(0);
    localparam logic [N_REQ-1:0]  GNT_ZRO   = {N_REQ{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZRO  = {DATA_W{1'b0}};

    arb_state_e          state_r,    state_nxt_s;
    logic [N_REQ-1:0]    gnt_r,      gnt_nxt_s;
    logic [OW-1:0]       owner_r,    owner_nxt_s;
    logic [OW-1:0]       ptr_r,      ptr_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;
    logic [TURN_W-1:0]   turn_cnt_r, turn_cnt_nxt_s;
    logic                timeout_r,  timeout_nxt_s;

    logic [OW-1:0]       pick_idx_s;
    logic                pick_found_s;
    logic [N_REQ-1:0]    pick_oh_s;
    logic                owner_req_s;
    logic                owner_last_s;
    logic                last_beat_s;
    logic                hold_hit_s;
    logic                release_s;
    logic                valid_s;
    logic [DATA_W-1:0]   x_sel_s, y_sel_s, z_sel_s;

    rr_prio_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // One-hot form of the arbitration winner
    always_comb begin
        pick_oh_s = GNT_ZRO;
        for (int k = 0; k < N_REQ; k++) begin
            pick_oh_s[k] = pick_found_s && (pick_idx_s == OW'(k));
        end
    end

    // Owner view of the request lines; gnt_r is zero outside OWN, so these
    // are inactive in IDLE and TURN without an explicit state check
    always_comb begin
        owner_req_s  = |(i_req & gnt_r);
        owner_last_s = |(i_last & gnt_r);
        last_beat_s  = owner_req_s && owner_last_s;
        hold_hit_s   = (hold_cnt_r == HOLD_LAST);
        release_s    = !owner_req_s || last_beat_s || hold_hit_s;
        valid_s      = (state_r == OWN) && owner_req_s;
    end

    // AND-OR data mux selected by the registered one-hot grant
    always_comb begin
        x_sel_s = DATA_ZRO;
        y_sel_s = DATA_ZRO;
        z_sel_s = DATA_ZRO;
        for (int k = 0; k < N_REQ; k++) begin
            x_sel_s = x_sel_s | (i_x[k*DATA_W +: DATA_W] & {DATA_W{gnt_r[k]}});
            y_sel_s = y_sel_s | (i_y[k*DATA_W +: DATA_W] & {DATA_W{gnt_r[k]}});
            z_sel_s = z_sel_s | (i_z[k*DATA_W +: DATA_W] & {DATA_W{gnt_r[k]}});
        end
    end

    // Arbiter next-state, grant, pointer and counter logic
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        owner_nxt_s    = owner_r;
        ptr_nxt_s      = ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        turn_cnt_nxt_s = turn_cnt_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s    = OWN;
                    gnt_nxt_s      = pick_oh_s;
                    owner_nxt_s    = pick_idx_s;
                    hold_cnt_nxt_s = HOLD_ZRO;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            OWN: begin
                hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                if (release_s) begin
                    state_nxt_s    = TURN;
                    gnt_nxt_s      = GNT_ZRO;
                    turn_cnt_nxt_s = TURN_ZRO;
                    // Released owner takes lowest priority next round
                    if (owner_r == OWNER_MAX) begin
                        ptr_nxt_s = OWNER_ZRO;
                    end else begin
                        ptr_nxt_s = owner_r + OWNER_ONE;
                    end
                    // Only a hold-limit cut of a still-active, non-final beat
                    // counts as a timeout
                    timeout_nxt_s  = hold_hit_s && owner_req_s && !owner_last_s;
                end else begin
                    state_nxt_s    = OWN;
                end
            end
            TURN: begin
                if (turn_cnt_r == TURN_LAST) begin
                    state_nxt_s    = IDLE;
                end else begin
                    turn_cnt_nxt_s = turn_cnt_r + TURN_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = GNT_ZRO;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_r    <= IDLE;
            gnt_r      <= GNT_ZRO;
            owner_r    <= OWNER_ZRO;
            ptr_r      <= OWNER_ZRO;
            hold_cnt_r <= HOLD_ZRO;
            turn_cnt_r <= TURN_ZRO;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            owner_r    <= owner_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            turn_cnt_r <= turn_cnt_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign o_gnt     = gnt_r;
    assign o_owner   = owner_r;
    assign o_timeout = timeout_r;
    assign o_valid   = valid_s;
    assign o_x       = valid_s ? x_sel_s : DATA_ZRO;
    assign o_y       = valid_s ? y_sel_s : DATA_ZRO;
    assign o_z       = valid_s ? z_sel_s : DATA_ZRO;

endmodule
